// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, PC sequencing/redirect, small in-order instruction FIFO.
// Optional retired-fetch counter port enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_ena,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt
`endif
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_REQ, S_WAIT} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fifo_ent_t;

  state_e                    state;
  logic                      discard;
  logic [ADDR_W-1:0]         req_pc;
  fifo_ent_t [DEPTH-1:0]     mem;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;

  logic [ADDR_W-1:0]         pc_seq;
  logic                      grant, resp, push, pop;

  assign pc_seq    = pc_in + ADDR_W'(PC_STEP);
  assign imem_addr = pc_in;

  // Only REQ issues, and only while no request is in flight, so count alone bounds occupancy.
  assign imem_req = !rst && (state == S_REQ) && !redirect_valid && (count < CNT_W'(DEPTH));
  assign grant    = imem_req && imem_gnt;
  assign pc_ena   = !rst && (redirect_valid || grant);
  assign pc_next  = (!rst && redirect_valid) ? redirect_pc : pc_seq;

  assign resp       = (state == S_WAIT) && imem_rvalid;
  assign push       = resp && !discard && !redirect_valid;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = mem[rd_ptr].data;
  assign inst_pc    = mem[rd_ptr].pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_REQ;
      discard <= 1'b0;
      req_pc  <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (grant) begin
            req_pc <= pc_in;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response arriving with the redirect is dropped right here; otherwise mark it stale.
          if (imem_rvalid) begin
            state   <= S_REQ;
            discard <= 1'b0;
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: req_pc, data: imem_rdata};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_fetch_cnt <= '0;
    else if (pop)
      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bench plays pcreg by loading pc_next whenever pc_ena is seen at an edge.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, redirect_pc, imem_rdata;
  logic        redirect_valid, imem_gnt, imem_rvalid, inst_ready;
  logic [31:0] pc_next, imem_addr, inst_data, inst_pc;
  logic        pc_ena, imem_req, inst_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
`endif
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_next(pc_next), .pc_ena(pc_ena),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rpc);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    inst_ready = rdy; redirect_valid = rdr; redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    logic        en;
    logic [31:0] nx;
    en = pc_ena; nx = pc_next;
    @(posedge clk); #1;
    if (en) pc_in = nx;
  endtask

  initial begin
    rst = 1'b1; pc_in = 32'h1000;
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_ena", pc_ena, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc_next", pc_next, 32'h1004);
    chk("rst_addr", imem_addr, 32'h1000);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    tick(); rst = 1'b0;

    // sequential fetch
    drive(1, 0, 0, 1, 0, 0);
    chk("seq_req0", imem_req, 1);
    chk("seq_addr0", imem_addr, 32'h1000);
    chk("seq_ena0", pc_ena, 1);
    chk("seq_next0", pc_next, 32'h1004);
    tick();
    drive(1, 1, 32'hA0A0A0A0, 1, 0, 0);
    chk("wait_req", imem_req, 0);
    chk("wait_ena", pc_ena, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0);
    chk("lat_valid", inst_valid, 1);
    chk("seq_pc0", inst_pc, 32'h1000);
    chk("seq_data0", inst_data, 32'hA0A0A0A0);
    chk("seq_addr1", imem_addr, 32'h1004);
    chk("seq_next1", pc_next, 32'h1008);
    chk("seq_ena1", pc_ena, 1);
    tick();
    drive(0, 1, 32'hB0B0B0B0, 1, 0, 0);
    chk("seq_novalid", inst_valid, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("seq_pc1", inst_pc, 32'h1004);
    chk("seq_data1", inst_data, 32'hB0B0B0B0);
    chk("nognt_req", imem_req, 1);
    chk("nognt_ena", pc_ena, 0);
    tick();

    // backpressure: two grants fill the FIFO
    drive(1, 0, 0, 0, 0, 0);
    chk("bp_addr0", imem_addr, 32'h1008);
    tick();
    drive(0, 1, 32'hC1C1C1C1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("bp_req1", imem_req, 1);
    chk("bp_addr1", imem_addr, 32'h100C);
    tick();
    drive(0, 1, 32'hC2C2C2C2, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("bp_full_req", imem_req, 0);
    chk("bp_full_ena", pc_ena, 0);
    chk("bp_full_pc", inst_pc, 32'h1008);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("bp_full_req2", imem_req, 0);
    chk("bp_pop_data0", inst_data, 32'hC1C1C1C1);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("bp_pop_pc1", inst_pc, 32'h100C);
    chk("bp_pop_data1", inst_data, 32'hC2C2C2C2);
    chk("bp_resume_req", imem_req, 1);
    chk("bp_resume_addr", imem_addr, 32'h1010);
    tick();

    // redirect while the 0x1010 response is pending, FIFO holding 0x100C
    drive(0, 0, 0, 0, 1, 32'h2000);
    chk("rd_valid_pre", inst_valid, 1);
    chk("rd_ena", pc_ena, 1);
    chk("rd_next", pc_next, 32'h2000);
    chk("rd_req", imem_req, 0);
    tick();
    drive(0, 1, 32'hDEADBEEF, 1, 0, 0);
    chk("rd_flushed", inst_valid, 0);
    chk("rd_wait_req", imem_req, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0);
    chk("rd_dropped", inst_valid, 0);
    chk("rd_addr", imem_addr, 32'h2000);
    tick();
    drive(0, 1, 32'h22222222, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("rd_pc", inst_pc, 32'h2000);
    chk("rd_data", inst_data, 32'h22222222);
    tick();

    // PC wrap
    pc_in = 32'hFFFFFFFC;
    drive(1, 0, 0, 0, 0, 0);
    chk("wrap_next", pc_next, 32'h0);
    chk("wrap_ena", pc_ena, 1);
    tick();
    drive(0, 1, 32'h33333333, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("wrap_pc", inst_pc, 32'hFFFFFFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    tick();

    // reset mid-WAIT with one FIFO entry
    drive(0, 0, 0, 0, 0, 0);
    chk("mid_valid_pre", inst_valid, 1);
    rst = 1'b1; #1;
    chk("mid_rst_valid", inst_valid, 0);
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_ena", pc_ena, 0);
    chk("mid_rst_next", pc_next, 32'h8);
    chk("mid_rst_data", inst_data, 0);
    chk("mid_rst_pc", inst_pc, 0);
    tick(); rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 32'h4);
    tick();

    // redirect coinciding with the response
    drive(0, 1, 32'hBADBAD00, 0, 1, 32'h3000);
    chk("rdv_next", pc_next, 32'h3000);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("rdv_dropped", inst_valid, 0);
    chk("rdv_req", imem_req, 1);
    chk("rdv_addr", imem_addr, 32'h3000);
    tick();

`ifdef FETCH_PERF_CNT_EN
    rst = 1'b1; #1;
    chk("perf_rst", perf_fetch_cnt, 0);
    tick(); rst = 1'b0; pc_in = 32'h4000;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 1, 0, 0); tick();
      drive(0, 1, 32'h1 + i, 1, 0, 0); tick();
    end
    drive(0, 0, 0, 1, 0, 0); tick();
    chk("perf_5", perf_fetch_cnt, 5);
    drive(0, 0, 0, 0, 1, 32'h5000); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 1, 0, 0); tick();
      drive(0, 1, 32'h10 + i, 1, 0, 0); tick();
    end
    drive(0, 0, 0, 1, 0, 0); tick();
    chk("perf_7", perf_fetch_cnt, 7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
